// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA stream arbiter: FSM state encoding,
// the index-width function and the effective-priority type.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_WORK,
        ST_RELEASE
    } dma_state_e;

    localparam int unsigned DMA_PL_W = 2;

    // One extra bit above the programmed level leaves room for the aged level.
    typedef logic [DMA_PL_W:0] dma_eff_pl_t;

    function automatic int unsigned dma_log2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << r) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_stream_arbiter_rr_picker.sv
// dma_rr_picker: combinational picker that selects the highest effective priority
// among eligible streams, breaking ties round-robin starting after ptr_i.
module dma_rr_picker
    import dma_pkg::*;
#(
    parameter int unsigned NUMB_CH = 8,
    parameter int unsigned PL_W    = 2
) (
    input  logic [NUMB_CH-1:0]            eligible_i,
    input  logic [NUMB_CH*(PL_W+1)-1:0]   eff_pl_i,
    input  logic [dma_log2(NUMB_CH)-1:0]  ptr_i,
    output logic [dma_log2(NUMB_CH)-1:0]  winner_o,
    output logic                          valid_o
);
    localparam int unsigned SEL_W = dma_log2(NUMB_CH);
    localparam int unsigned EPW   = PL_W + 1;

    logic [EPW-1:0]     max_pl;
    logic [NUMB_CH-1:0] cand;
    int unsigned        idx;
    logic [SEL_W-1:0]   idx_s;

    always_comb begin
        max_pl = '0;
        for (int unsigned k = 0; k < NUMB_CH; k++) begin
            if (eligible_i[k] && (eff_pl_i[k*EPW +: EPW] > max_pl)) begin
                max_pl = eff_pl_i[k*EPW +: EPW];
            end
        end
        for (int unsigned k = 0; k < NUMB_CH; k++) begin
            cand[k] = eligible_i[k] && (eff_pl_i[k*EPW +: EPW] == max_pl);
        end
    end

    // Offsets 1..NUMB_CH visit every stream once, the last granted one last.
    always_comb begin
        winner_o = ptr_i;
        valid_o  = 1'b0;
        idx      = 0;
        idx_s    = '0;
        for (int unsigned off = 1; off <= NUMB_CH; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= NUMB_CH) idx = idx - NUMB_CH;
            idx_s = idx[SEL_W-1:0];
            if (!valid_o && cand[idx_s]) begin
                valid_o  = 1'b1;
                winner_o = idx_s;
            end
        end
    end

endmodule

// File: rtl/dma_stream_arbiter.sv
// DMA stream arbiter: grants one stream at a time to the master by priority and
// round-robin. Optional starvation aging is enabled by defining DMA_ARB_AGING_EN.
module dma_stream_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUMB_CH = 8,
    parameter int unsigned PL_W    = 2,
    parameter int unsigned BEAT_W  = 5,
    parameter int unsigned AGE_W   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUMB_CH-1:0]            i_en_stream,
    input  logic [NUMB_CH-1:0]            i_request,
    input  logic [NUMB_CH*PL_W-1:0]       i_pl,
    input  logic [NUMB_CH*BEAT_W-1:0]     i_beats,
    input  logic                          i_master_ready,
    input  logic                          i_beat_done,
    output logic [dma_log2(NUMB_CH)-1:0]  o_stream_sel,
    output logic                          o_master_en,
    output logic                          o_grant_done
);
    localparam int unsigned SEL_W = dma_log2(NUMB_CH);
    localparam int unsigned EPW   = PL_W + 1;

    dma_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;

    logic [NUMB_CH-1:0]       eligible;
    logic [NUMB_CH-1:0]       age_sat;
    logic [NUMB_CH*EPW-1:0]   eff_pl;
    logic [BEAT_W-1:0]        beats_a [NUMB_CH];
    logic [SEL_W-1:0]         pick_idx;
    logic                     pick_valid;

    assign eligible = i_en_stream & i_request;

    always_comb begin
        for (int unsigned k = 0; k < NUMB_CH; k++) begin
            beats_a[k] = i_beats[k*BEAT_W +: BEAT_W];
            eff_pl[k*EPW +: EPW] = age_sat[k] ? {1'b1, {PL_W{1'b0}}}
                                              : {1'b0, i_pl[k*PL_W +: PL_W]};
        end
    end

    dma_rr_picker #(
        .NUMB_CH (NUMB_CH),
        .PL_W    (PL_W)
    ) u_picker (
        .eligible_i (eligible),
        .eff_pl_i   (eff_pl),
        .ptr_i      (last_q),
        .winner_o   (pick_idx),
        .valid_o    (pick_valid)
    );

`ifdef DMA_ARB_AGING_EN
    logic [NUMB_CH-1:0][AGE_W-1:0] age_q, age_d;
    logic                          grant_evt;

    assign grant_evt = (state_q == ST_ARB) && pick_valid && i_master_ready;

    always_comb begin
        age_d = age_q;
        for (int unsigned k = 0; k < NUMB_CH; k++) begin
            age_sat[k] = (age_q[k] == '1);
            if (!i_en_stream[k]) begin
                age_d[k] = '0;
            end else if (grant_evt) begin
                if (SEL_W'(k) == pick_idx) begin
                    age_d[k] = '0;
                end else if (eligible[k] && !age_sat[k]) begin
                    age_d[k] = age_q[k] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) age_q <= '0;
        else         age_q <= age_d;
    end
`else
    assign age_sat = '0;

    // AGE_W only sizes the age counters, which this build does not contain.
    if (AGE_W == 0) begin : g_no_age_counters
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_ARB;
            ST_ARB: begin
                if (pick_valid && i_master_ready) begin
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = (beats_a[pick_idx] == '0) ? BEAT_W'(1) : beats_a[pick_idx];
                    state_d = ST_WORK;
                end
            end
            ST_WORK: begin
                // A disabled stream ends the grant even if its last beat lands now.
                if (!i_en_stream[sel_q]) begin
                    state_d = ST_RELEASE;
                end else if (i_beat_done) begin
                    if (cnt_q == BEAT_W'(1)) state_d = ST_RELEASE;
                    else                     cnt_d   = cnt_q - BEAT_W'(1);
                end
            end
            ST_RELEASE: state_d = ST_ARB;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUMB_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stream_sel = sel_q;
    assign o_master_en  = (state_q == ST_WORK);
    assign o_grant_done = (state_q == ST_RELEASE);

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Self-checking bench for dma_stream_arbiter: directed stimulus pushes expected
// grant indices into a queue that a negedge monitor pops on each new grant.
module tb_dma_stream_arbiter;
    localparam int unsigned NCH = 8;
    localparam int unsigned PLW = 2;
    localparam int unsigned BW  = 5;
    localparam int unsigned AW  = 4;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    req;
    logic [NCH*PLW-1:0] pl;
    logic [NCH*BW-1:0] beats;
    logic              ready;
    logic              beat_done;
    logic [2:0]        sel;
    logic              master_en;
    logic              grant_done;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];
    logic prev_en = 1'b0;

    dma_stream_arbiter #(
        .NUMB_CH (NCH),
        .PL_W    (PLW),
        .BEAT_W  (BW),
        .AGE_W   (AW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_en_stream    (en),
        .i_request      (req),
        .i_pl           (pl),
        .i_beats        (beats),
        .i_master_ready (ready),
        .i_beat_done    (beat_done),
        .o_stream_sel   (sel),
        .o_master_en    (master_en),
        .o_grant_done   (grant_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pl(input int k, input int v);
        pl[k*PLW +: PLW] = PLW'(v);
    endtask

    task automatic set_beats(input int k, input int v);
        beats[k*BW +: BW] = BW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        check("rst_sel", sel, 0);
        check("rst_master_en", master_en, 0);
        check("rst_grant_done", grant_done, 0);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int budget;
        budget = 30;
        step(1);
        while (!master_en && budget > 0) begin
            step(1);
            budget--;
        end
        if (!master_en) check(name, master_en, 1);
    endtask

    task automatic serve(input int nb);
        wait_grant("grant_timeout");
        beat_done = 1'b1;
        step(nb);
        beat_done = 1'b0;
        check("serve_grant_done", grant_done, 1);
    endtask

    // Monitor: each new grant must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            if (master_en && !prev_en) begin
                if (exp_q.size() == 0) check("grant_unexpected", exp_q.size(), 1);
                else check("grant_sel", sel, exp_q.pop_front());
            end
            if (grant_done) check("done_with_en", master_en, 0);
            prev_en = master_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = '1; req = '0; pl = '0; beats = '0;
        ready = 1'b1; beat_done = 1'b0;

        // Single eligible stream, 4 beats, request withdrawn mid-grant.
        for (int k = 0; k < NCH; k++) set_beats(k, 1);
        set_beats(2, 4);
        req = 8'b0000_0100;
        do_reset();
        exp_q.push_back(2);
        step(1);
        check("t1_arb_en", master_en, 0);
        step(1);
        check("t1_en_cycle3", master_en, 1);
        check("t1_sel", sel, 2);
        req = '0;
        beat_done = 1'b1;
        step(3);
        check("t1_en_after3", master_en, 1);
        check("t1_done_after3", grant_done, 0);
        step(1);
        beat_done = 1'b0;
        check("t1_done", grant_done, 1);
        check("t1_en_off", master_en, 0);
        step(1);
        check("t1_done_pulse", grant_done, 0);

        // Equal-priority round robin.
        for (int k = 0; k < NCH; k++) set_pl(k, 1);
        req = 8'b0010_1010;
        do_reset();
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(1);
        repeat (4) serve(1);
        req = '0;

        // High priority stream 4 against low priority stream 0.
        for (int k = 0; k < NCH; k++) set_pl(k, 0);
        set_pl(4, 3);
        req = 8'b0001_0001;
        do_reset();
        for (int i = 0; i < 16; i++) begin
`ifdef DMA_ARB_AGING_EN
            exp_q.push_back(i == 15 ? 0 : 4);
`else
            exp_q.push_back(4);
`endif
        end
        repeat (16) serve(1);
        req = '0;

        // Abort by disable with simultaneous beat, counter at 3.
        for (int k = 0; k < NCH; k++) set_pl(k, 1);
        set_beats(6, 5);
        req = 8'b0100_0000;
        do_reset();
        exp_q.push_back(6);
        wait_grant("t4_grant_timeout");
        beat_done = 1'b1;
        step(2);
        en[6] = 1'b0;
        step(1);
        check("t4_abort_done", grant_done, 1);
        check("t4_abort_en", master_en, 0);
        beat_done = 1'b0;
        req = '0;
        en = '1;

        // Reset mid-grant: no done pulse, first tie goes to stream 0.
        set_beats(3, 4);
        req = 8'b0000_1000;
        exp_q.push_back(3);
        wait_grant("t5_grant_timeout");
        beat_done = 1'b1;
        step(1);
        beat_done = 1'b0;
        rst = 1'b1;
        req = '0;
        step(1);
        check("t5_rst_en", master_en, 0);
        check("t5_rst_sel", sel, 0);
        check("t5_rst_done", grant_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t5_no_done", grant_done, 0);
        end
        req = 8'b0000_1001;
        exp_q.push_back(0);
        serve(1);
        req = '0;

        // Master not ready: grant held off, then one cycle after ready.
        ready = 1'b0;
        req = 8'b0000_0110;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t6_hold_en", master_en, 0);
            check("t6_hold_sel", sel, 0);
        end
        ready = 1'b1;
        exp_q.push_back(1);
        step(1);
        check("t6_grant_en", master_en, 1);
        check("t6_grant_sel", sel, 1);
        req = '0;
        beat_done = 1'b1;
        step(1);
        beat_done = 1'b0;
        check("t6_done", grant_done, 1);
        step(3);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
